// File: rtl/subtractor_8bit_serial.sv
// Bit-serial unsigned subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Operands in and result out are each a valid/ready handshake; outputs come only from flops.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | shifting one bit per edge through the borrow chain
// DONE  | result held on diff/borrow_out, out_valid=1
module subtractor_8bit_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             borrow_out_q, borrow_out_d;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_q        <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            br_q         <= 1'b0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_q        <= res_d;
            diff_q       <= diff_d;
            cnt_q        <= cnt_d;
            br_q         <= br_d;
            borrow_out_q <= borrow_out_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_d        = res_q;
        diff_d       = diff_q;
        cnt_d        = cnt_q;
        br_d         = br_q;
        borrow_out_d = borrow_out_q;

        // Full-subtractor slice on the current LSBs
        d_bit       = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
        br_next     = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
        res_shifted = {d_bit, res_q[WIDTH-1:1]};

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_CALC;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = borrow_in;
                    res_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_CALC: begin
                res_d  = res_shifted;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d      = S_DONE;
                    diff_d       = res_shifted;
                    borrow_out_d = br_next;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_subtractor_8bit_serial.sv
// Directed and random checks for the bit-serial subtractor against hand-computed results.
module tb_subtractor_8bit_serial;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       borrow_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       borrow_out;

    int tests_run;
    int tests_failed;

    subtractor_8bit_serial #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one operation, counts edges to out_valid, then completes the output handshake.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                          input int stall, input bit early,
                          output logic [7:0] rd, output logic rbo, output int lat,
                          output bit timed_out);
        timed_out = 1'b0;
        lat = 0;
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        a = ta; b = tb_v; borrow_in = tbin; in_valid = 1'b1;
        out_ready = early;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) begin
            timed_out = 1'b1;
            rd = 'x;
            rbo = 1'bx;
            out_ready = 1'b0;
            return;
        end
        rd = diff;
        rbo = borrow_out;
        if (!early) begin
            for (int s = 0; s < stall; s++) tick();
            out_ready = 1'b1;
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b diff=%h borrow_out=%b, required 1 0 00 0",
                     in_ready, out_valid, diff, borrow_out);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] rd; logic rbo; int lat; bit to;
        run_op(8'h5A, 8'h23, 1'b0, 0, 1'b0, rd, rbo, lat, to);
        tests_run++;
        if (to || lat != 8) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d edges (timeout=%0b), required 8", lat, to);
        end
        tests_run++;
        if (rd !== 8'h37 || rbo !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_result: diff=%h borrow_out=%b, required 37 0", rd, rbo);
        end
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_return_idle: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_borrow();
        logic [7:0] va [3] = '{8'h00, 8'h10, 8'hFF};
        logic [7:0] vb [3] = '{8'h01, 8'h10, 8'h00};
        logic       vi [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] ed [3] = '{8'hFF, 8'hFF, 8'hFE};
        logic       eb [3] = '{1'b1, 1'b1, 1'b0};
        logic [7:0] rd; logic rbo; int lat; bit to;
        for (int i = 0; i < 3; i++) begin
            // Early out_ready must not shorten latency or skip DONE
            run_op(va[i], vb[i], vi[i], 0, (i == 1), rd, rbo, lat, to);
            tests_run++;
            if (to || lat != 8 || rd !== ed[i] || rbo !== eb[i]) begin
                tests_failed++;
                $display("FAIL borrow_case%0d: diff=%h borrow_out=%b lat=%0d, required %h %b 8",
                         i, rd, rbo, lat, ed[i], eb[i]);
            end
        end
    endtask

    task automatic test_reset_mid_calc();
        bit seen;
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        a = 8'h5A; b = 8'h23; borrow_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_calc: in_ready=%b out_valid=%b diff=%h borrow_out=%b, required 1 0 00 0",
                     in_ready, out_valid, diff, borrow_out);
        end
        tick(); tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        tests_run++;
        if (seen || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_no_result: out_valid_seen=%b in_ready=%b, required 0 1", seen, in_ready);
        end
    endtask

    task automatic test_restart_after_reset();
        logic [7:0] rd; logic rbo; int lat; bit to;
        run_op(8'h80, 8'h01, 1'b1, 2, 1'b0, rd, rbo, lat, to);
        tests_run++;
        if (to || lat != 8 || rd !== 8'h7E || rbo !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_after_reset: diff=%h borrow_out=%b lat=%0d, required 7e 0 8", rd, rbo, lat);
        end
    endtask

    task automatic test_backpressure();
        bit stable;
        bit found;
        logic [7:0] rd; logic rbo; int lat; bit to;
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        a = 8'h3C; b = 8'h5D; borrow_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            found = out_valid;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL backpressure_reach_done: out_valid never rose, required 1");
        end
        stable = 1'b1;
        for (int s = 0; s < 5; s++) begin
            a = 8'(s * 17 + 1); b = 8'(s * 3); borrow_in = s[0]; in_valid = ~s[0];
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 8'hDF || borrow_out !== 1'b1)
                stable = 1'b0;
        end
        tests_run++;
        if (!stable) begin
            tests_failed++;
            $display("FAIL backpressure_hold: out_valid=%b in_ready=%b diff=%h borrow_out=%b, required 1 0 df 1",
                     out_valid, in_ready, diff, borrow_out);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        tick();
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_no_accept: in_ready=%b, required 1", in_ready);
        end
        run_op(8'h01, 8'h01, 1'b0, 0, 1'b0, rd, rbo, lat, to);
        tests_run++;
        if (to || rd !== 8'h00 || rbo !== 1'b0) begin
            tests_failed++;
            $display("FAIL backpressure_next_op: diff=%h borrow_out=%b, required 00 0", rd, rbo);
        end
    endtask

    task automatic test_operand_stability();
        bit found;
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        a = 8'hC3; b = 8'h3C; borrow_in = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            a = 8'($urandom); b = 8'($urandom); borrow_in = 1'($urandom);
            tick();
            found = out_valid;
        end
        tests_run++;
        if (!found || diff !== 8'h86 || borrow_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL operand_stability: found=%b diff=%h borrow_out=%b, required 1 86 0",
                     found, diff, borrow_out);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] ra, rb, rd;
        logic       rbin, rbo;
        logic [8:0] model;
        int         lat;
        bit         to;
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            model = {1'b0, ra} - {1'b0, rb} - {8'b0, rbin};
            run_op(ra, rb, rbin, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                   rd, rbo, lat, to);
            tests_run++;
            if (to || {rbo, rd} !== model) begin
                tests_failed++;
                $display("FAIL random_model: a=%h b=%h bin=%b got %b_%h, required %b_%h",
                         ra, rb, rbin, rbo, rd, model[8], model[7:0]);
            end
            tests_run++;
            if (8'(rd + rb + {7'b0, rbin}) !== ra) begin
                tests_failed++;
                $display("FAIL random_identity: a=%h b=%h bin=%b diff=%h gives %h, required %h",
                         ra, rb, rbin, rd, 8'(rd + rb + {7'b0, rbin}), ra);
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; borrow_in = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_borrow();
        test_reset_mid_calc();
        test_restart_after_reset();
        test_backpressure();
        test_operand_stability();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/subtractor_8bit_serial.md
# subtractor_8bit_serial

Bit-serial unsigned subtractor with borrow, the inverse arithmetic unit to the team's 8-bit parallel adder. It accepts operands a, b and borrow_in over a valid/ready input handshake. It computes diff = a − b − borrow_in one bit per clock, LSB first, and presents diff and borrow_out over a valid/ready output handshake. It trades latency for area in datapaths that need occasional subtraction or compare-by-subtract.

## Interface
- WIDTH, 8, operand and result width in bits (≥2); counter width is clog2(WIDTH+1)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operands a, b, borrow_in are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend, unsigned
- b  input  WIDTH  subtrahend, unsigned
- borrow_in  input  1  incoming borrow
- out_valid  output  1  diff and borrow_out are valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (a − b − borrow_in) mod 2^WIDTH
- borrow_out  output  1  1 iff a < b + borrow_in (unsigned, full precision)

## Operation
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - CALC: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE to CALC: on the edge where in_valid && in_ready.
  - Latch a and b into shift registers.
  - Load the borrow register with borrow_in.
  - Clear the bit counter.
- CALC, each edge, with ai=a_sh[0], bi=b_sh[0], br=borrow reg:
  - d = ai ^ bi ^ br.
  - br_next = (~ai & bi) | (~(ai ^ bi) & br).
  - Shift d into the result register MSB-first, so bit 0 ends at LSB after WIDTH shifts.
  - Shift the operands right by one.
  - Increment the counter.
- CALC to DONE: on the edge that processes bit WIDTH−1.
  - Copy the result into the diff output register.
  - Copy the final br into borrow_out.
- DONE to IDLE: on the edge where out_valid && out_ready.
- in_valid is ignored outside IDLE. Operands are sampled only at acceptance; later input changes have no effect.
- diff and borrow_out change only on the CALC to DONE edge and at reset. They hold their last value in IDLE and CALC and are meaningful only while out_valid=1.
- Arithmetic identity: {borrow_out, diff} equals the 2's-complement of (a − b − borrow_in) over WIDTH+1 bits. Equivalently, a = (diff + b + borrow_in) mod 2^WIDTH.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff=0, borrow_out=0, counter=0. These take effect immediately on rst_n fall, without waiting for a clock edge.
- in_ready and out_valid are decoded directly from the state register. There is no combinational path from any input to any output.
- Latency: with acceptance at edge E0, out_valid rises after edge E_WIDTH. For WIDTH=8 that is 8 edges after acceptance.
- Throughput: with out_ready held high, a new accept can occur every WIDTH+2 cycles (accept, WIDTH calc, output handshake).
- Backpressure: while out_valid=1 and out_ready=0, out_valid, diff and borrow_out hold stable indefinitely.
- Simultaneous events: out_ready asserted before DONE has no effect. The handshake completes on the first DONE edge with out_ready=1.
- Reset mid-operation: asserting rst_n in CALC or DONE aborts the operation and loads the reset values.
  - No out_valid pulse follows for the aborted operation.
  - After rst_n rises, the first accept restarts cleanly.
- Counter and shift registers wrap or clear only via state transitions. No stale bits carry from one operation to the next.

## Test plan
- Reset: hold rst_n=0 mid-CALC, then release. Required: in_ready=1, out_valid=0, diff=0x00, borrow_out=0 immediately on assertion, and no result appears afterward.
- Basic, WIDTH=8: a=0x5A, b=0x23, borrow_in=0. Required: diff=0x37, borrow_out=0, out_valid high exactly 8 edges after the accept edge.
- Borrow cases:
  - a=0x00, b=0x01, borrow_in=0 gives diff=0xFF, borrow_out=1.
  - a=0x10, b=0x10, borrow_in=1 gives diff=0xFF, borrow_out=1.
  - a=0xFF, b=0x00, borrow_in=1 gives diff=0xFE, borrow_out=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands. Required:
  - out_valid, diff and borrow_out stay stable.
  - in_ready=0 and the new operands are not accepted.
  - After out_ready=1 for one edge, the block returns to IDLE with in_ready=1.
- Operand stability: change a and b every cycle during CALC. Required: the result matches the operands sampled at acceptance.
- Random regression: 1000 operations with random a, b, borrow_in and random out_ready stalls. Each result is checked against the model {borrow_out, diff} = {1'b0, a} − b − borrow_in. Also check the identity (diff + b + borrow_in) mod 256 == a.
